// File: rtl/cnv_prec_seq_pkg.sv
// cnv_prec_seq_pkg: shared data-configuration types, defaults and sequencer state enum
package cnv_prec_seq_pkg;
  typedef struct packed {
    logic [7:0] prec;
    logic [7:0] frac;
  } dconf_t;
  localparam dconf_t DEF_DCONF_INT = '{prec: 8'd8, frac: 8'd0};
  localparam dconf_t DEF_DCONF_FXP = '{prec: 8'd16, frac: 8'd8};
  typedef enum logic [1:0] {IDLE, CONV, OUT} cnv_seq_state_t;
  typedef struct packed {
    logic udf;
    logic ovf;
    logic rnd;
  } cnv_flags_t;
endpackage

// File: rtl/cnv_prec_seq_if.sv
// cnv_prec_seq_if: vector handshake and status bundle for the conversion sequencer
interface cnv_prec_seq_if #(
  parameter int LANES = 4,
  parameter int I_PREC = 8,
  parameter int O_PREC = 16,
  parameter int CNT_W = 16
);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [LANES*I_PREC-1:0] in_data;
  logic [LANES*O_PREC-1:0] out_data;
  logic out_udf, out_ovf, out_rnd;
  logic st_clr, st_udf, st_ovf, st_rnd;
  logic [CNT_W-1:0] ovf_cnt;
  modport master (
    output in_valid, in_data, out_ready, st_clr,
    input in_ready, out_valid, out_data, out_udf, out_ovf, out_rnd, st_udf, st_ovf, st_rnd, ovf_cnt
  );
  modport slave (
    input in_valid, in_data, out_ready, st_clr,
    output in_ready, out_valid, out_data, out_udf, out_ovf, out_rnd, st_udf, st_ovf, st_rnd, ovf_cnt
  );
endinterface

// File: rtl/cnv_prec.sv
// cnv_prec: signed fixed-point precision converter, rounds toward -inf and saturates on overflow
module cnv_prec
  import cnv_prec_seq_pkg::*;
#(
  parameter dconf_t I_CONF = DEF_DCONF_INT,
  parameter dconf_t O_CONF = DEF_DCONF_FXP,
  localparam int I_PREC = int'(I_CONF.prec),
  localparam int O_PREC = int'(O_CONF.prec)
) (
  input  logic [I_PREC-1:0] din,
  output logic [O_PREC-1:0] dout,
  output cnv_flags_t        flags
);
  localparam int I_FRAC = int'(I_CONF.frac);
  localparam int O_FRAC = int'(O_CONF.frac);
  localparam int LSH = O_FRAC > I_FRAC ? O_FRAC - I_FRAC : 0;
  localparam int RSH = I_FRAC > O_FRAC ? I_FRAC - O_FRAC : 0;
  localparam int W = (I_PREC + LSH > O_PREC ? I_PREC + LSH : O_PREC) + 1;
  localparam logic signed [W-1:0] OMAX = W'((64'sd1 <<< (O_PREC - 1)) - 64'sd1);
  localparam logic signed [W-1:0] OMIN = ~OMAX;
  logic signed [W-1:0] x, sh, y;
  always_comb begin
    x = {{(W - I_PREC){din[I_PREC-1]}}, din};
    sh = x <<< LSH;
    y = sh >>> RSH;
    flags.rnd = (y <<< RSH) != sh;
    flags.ovf = y > OMAX || y < OMIN;
    flags.udf = x != 0 && y == 0;
    dout = flags.ovf ? (y[W-1] ? OMIN[O_PREC-1:0] : OMAX[O_PREC-1:0]) : y[O_PREC-1:0];
  end
endmodule

// File: rtl/cnv_prec_seq.sv
// cnv_prec_seq: converts a packed vector lane by lane through one shared cnv_prec, with flags and counters
module cnv_prec_seq
  import cnv_prec_seq_pkg::*;
#(
  parameter dconf_t I_CONF = DEF_DCONF_INT,
  parameter dconf_t O_CONF = DEF_DCONF_FXP,
  parameter int LANES = 4,
  parameter int CNT_W = 16,
  localparam int I_PREC = int'(I_CONF.prec),
  localparam int O_PREC = int'(O_CONF.prec)
) (
  input logic clk,
  input logic reset,
  cnv_prec_seq_if.slave bus
);
  localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  cnv_seq_state_t state, state_d;
  logic [IW-1:0] idx;
  logic [LANES*I_PREC-1:0] ibuf;
  logic [LANES*O_PREC-1:0] obuf;
  logic [O_PREC-1:0] c_out;
  cnv_flags_t c_fl, ev, vfl, st;
  logic [CNT_W-1:0] cnt, cnt_base;
  cnv_prec #(.I_CONF(I_CONF), .O_CONF(O_CONF)) u_cnv (
    .din(ibuf[idx*I_PREC +: I_PREC]),
    .dout(c_out),
    .flags(c_fl)
  );
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = bus.in_valid ? CONV : IDLE;
      CONV:    state_d = idx == IW'(LANES - 1) ? OUT : CONV;
      OUT:     state_d = bus.out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  // a lane event seen together with st_clr survives the clear
  assign ev = state == CONV ? c_fl : '0;
  assign cnt_base = bus.st_clr ? '0 : cnt;
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == OUT;
  assign bus.out_data = obuf;
  assign {bus.out_udf, bus.out_ovf, bus.out_rnd} = vfl;
  assign {bus.st_udf, bus.st_ovf, bus.st_rnd} = st;
  assign bus.ovf_cnt = cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      ibuf <= '0;
      obuf <= '0;
      vfl <= '0;
      st <= '0;
      cnt <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && bus.in_valid) begin
        ibuf <= bus.in_data;
        vfl <= '0;
        idx <= '0;
      end
      if (state == CONV) begin
        obuf[idx*O_PREC +: O_PREC] <= c_out;
        vfl <= vfl | c_fl;
        idx <= idx + 1'b1;
      end
      st <= bus.st_clr ? ev : st | ev;
      cnt <= ev.ovf && cnt_base != CNT_MAX ? cnt_base + 1'b1 : cnt_base;
    end
  end
endmodule
